// File: rtl/uart_pkg.sv
// Shared UART definitions: symbol timing helpers, 8N1 frame constants and FSM encoding.
// Imported by both uart_receiver and uart_transmitter so the two sides agree on timing.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_e;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs (UART line, buttons, switches).
// RESET_VAL lets idle-high lines come out of reset without a false edge.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with mid-bit sampling and a one-byte valid/ready holding register.
// Framing errors and overruns are reported as single-cycle pulses.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int N  = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int S  = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(N);

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 rx_s;
  logic                 sample;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (serial_in),
    .q_o   (rx_s)
  );

  assign sample = (cnt_q == CW'(S));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CW'(N - 1)) ? '0 : cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q && !data_out_ready;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Restarting the counter here puts every later sample mid-symbol.
        if (rx_s == START_BIT) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (sample) begin
          if (rx_s == START_BIT) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (sample) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (sample) begin
          if (rx_s == STOP_BIT) begin
            state_d = IDLE;
            if (!valid_q || data_out_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            // A held-low line (break) must not be decoded as a stream of 0x00 frames.
            fe_d    = 1'b1;
            state_d = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s == STOP_BIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out       = data_q;
  assign data_out_valid = valid_q;
  assign framing_error  = fe_q;
  assign overrun        = ov_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at N=16, S=8 with a queue-based byte delivery model.
module tb_uart_receiver;

  localparam int CF = 160;
  localparam int BR = 10;
  localparam int N  = CF / BR;
  localparam int S  = N / 2;
  localparam int LAT = S + 3 + 9 * N;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       serial_in = 1'b1;
  logic       data_out_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Monitor results
  byte unsigned rxq[$];
  int  fe_cnt = 0;
  int  ov_cnt = 0;
  int  ov_cyc = -1;
  bit  mon_en = 1'b0;

  // Reference model state
  byte unsigned exp_q[$];
  int  exp_fe = 0;
  int  exp_ov = 0;
  bit  m_hold = 1'b0;
  byte unsigned m_byte = 8'h00;

  uart_receiver #(.CLOCK_FREQ(CF), .BAUD_RATE(BR)) dut (
    .clk            (clk),
    .reset          (reset),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (data_out_valid && data_out_ready) rxq.push_back(data_out);
      if (framing_error) fe_cnt++;
      if (overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
    end
  end

  function automatic logic [63:0] pack_q(input byte unsigned q[$]);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < q.size() && i < 8; i++) r[i*8 +: 8] = q[i];
    return r;
  endfunction

  task automatic clear_all();
    rxq.delete();
    exp_q.delete();
    fe_cnt = 0; ov_cnt = 0; ov_cyc = -1;
    exp_fe = 0; exp_ov = 0;
  endtask

  // A byte either reaches the consumer, waits in the holding register, or is lost.
  task automatic model_frame(input byte unsigned b, input bit stop_ok);
    if (!stop_ok) exp_fe++;
    else if (m_hold && !data_out_ready) exp_ov++;
    else if (data_out_ready) exp_q.push_back(b);
    else begin
      m_hold = 1'b1;
      m_byte = b;
    end
  endtask

  task automatic model_release();
    if (m_hold) exp_q.push_back(m_byte);
    m_hold = 1'b0;
  endtask

  // Called on a negedge; leaves the line at the stop-bit level.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    serial_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (N) @(negedge clk);
    end
    serial_in = stop;
    repeat (N) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, data_out_valid, framing_error, overrun} !== 11'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 000", {data_out, data_out_valid, framing_error, overrun});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_latency();
    int lat;
    clear_all();
    lat = -1;
    fork
      send_frame(8'h55, 1'b1);
      begin
        for (int j = 1; j <= 300; j++) begin
          @(negedge clk);
          #2;
          if (data_out_valid && lat < 0) lat = j - 1;
        end
      end
    join
    model_frame(8'h55, 1'b1);
    checks++;
    if (lat != LAT) begin
      failures++;
      $display("FAIL latency: got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (data_out !== 8'h55) begin
      failures++;
      $display("FAIL data_55: got %h expected 55", data_out);
    end
    checks++;
    if (pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size() || fe_cnt != exp_fe) begin
      failures++;
      $display("FAIL rx_55: got %h/%0d fe=%0d expected %h/%0d fe=%0d",
               pack_q(rxq), rxq.size(), fe_cnt, pack_q(exp_q), exp_q.size(), exp_fe);
    end
  endtask

  task automatic test_back_to_back();
    clear_all();
    send_frame(8'hA3, 1'b1);
    model_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    model_frame(8'h0F, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_bytes: got %h/%0d expected %h/%0d", pack_q(rxq), rxq.size(), pack_q(exp_q), exp_q.size());
    end
    checks++;
    if (ov_cnt != exp_ov || fe_cnt != exp_fe) begin
      failures++;
      $display("FAIL b2b_flags: got ov=%0d fe=%0d expected ov=%0d fe=%0d", ov_cnt, fe_cnt, exp_ov, exp_fe);
    end
  endtask

  task automatic test_overrun();
    int e0b;
    clear_all();
    data_out_ready = 1'b0;
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    e0b = cyc + 1;
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    repeat (4) @(negedge clk);
    #2;
    checks++;
    if (data_out !== m_byte || data_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovr_hold: got %h v=%b expected %h v=1", data_out, data_out_valid, m_byte);
    end
    checks++;
    if (ov_cnt != exp_ov || ov_cyc != e0b + LAT) begin
      failures++;
      $display("FAIL ovr_pulse: got n=%0d at %0d expected n=%0d at %0d", ov_cnt, ov_cyc, exp_ov, e0b + LAT);
    end
    @(negedge clk);
    data_out_ready = 1'b1;
    model_release();
    @(negedge clk);
    data_out_ready = 1'b0;
    @(negedge clk);
    #2;
    checks++;
    if (data_out_valid !== 1'b0 || pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL ovr_drain: got v=%b %h/%0d expected v=0 %h/%0d",
               data_out_valid, pack_q(rxq), rxq.size(), pack_q(exp_q), exp_q.size());
    end
    @(negedge clk);
    data_out_ready = 1'b1;
  endtask

  task automatic test_framing();
    clear_all();
    send_frame(8'hFF, 1'b0);
    model_frame(8'hFF, 1'b0);
    repeat (5 * N) @(negedge clk);
    checks++;
    if (fe_cnt != exp_fe || data_out_valid !== 1'b0 || rxq.size() != 0) begin
      failures++;
      $display("FAIL frame_err: got fe=%0d v=%b n=%0d expected fe=%0d v=0 n=0", fe_cnt, data_out_valid, rxq.size(), exp_fe);
    end
    serial_in = 1'b1;
    repeat (N) @(negedge clk);
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size() || fe_cnt != exp_fe) begin
      failures++;
      $display("FAIL frame_recover: got %h/%0d fe=%0d expected %h/%0d fe=%0d",
               pack_q(rxq), rxq.size(), fe_cnt, pack_q(exp_q), exp_q.size(), exp_fe);
    end
  endtask

  task automatic test_glitch();
    clear_all();
    serial_in = 1'b0;
    repeat (4) @(negedge clk);
    serial_in = 1'b1;
    repeat (2 * N) @(negedge clk);
    checks++;
    if (rxq.size() != 0 || fe_cnt != 0 || data_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL glitch: got n=%0d fe=%0d v=%b expected n=0 fe=0 v=0", rxq.size(), fe_cnt, data_out_valid);
    end
    send_frame(8'h42, 1'b1);
    model_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL glitch_next: got %h/%0d expected %h/%0d", pack_q(rxq), rxq.size(), pack_q(exp_q), exp_q.size());
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    clear_all();
    data_out_ready = 1'b0;
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h5A) begin
      failures++;
      $display("FAIL pre_reset: got %h v=%b expected 5a v=1", data_out, data_out_valid);
    end
    b = 8'h99;
    serial_in = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial_in = b[i];
      repeat (N) @(negedge clk);
    end
    serial_in = b[4];
    repeat (N / 2) @(negedge clk);
    reset = 1'b0;
    m_hold = 1'b0;
    #1;
    checks++;
    if ({data_out, data_out_valid, framing_error, overrun} !== 11'h0) begin
      failures++;
      $display("FAIL async_reset: got %h expected 000", {data_out, data_out_valid, framing_error, overrun});
    end
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    reset = 1'b1;
    repeat (N) @(negedge clk);
    data_out_ready = 1'b1;
    send_frame(8'h99, 1'b1);
    model_frame(8'h99, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size() || fe_cnt != 0) begin
      failures++;
      $display("FAIL post_reset: got %h/%0d fe=%0d expected %h/%0d fe=0",
               pack_q(rxq), rxq.size(), fe_cnt, pack_q(exp_q), exp_q.size());
    end
  endtask

  task automatic test_random();
    byte unsigned b;
    clear_all();
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
      model_frame(b, 1'b1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (pack_q(rxq) !== pack_q(exp_q) || rxq.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_bytes: got %h/%0d expected %h/%0d", pack_q(rxq), rxq.size(), pack_q(exp_q), exp_q.size());
    end
    checks++;
    if (fe_cnt != 0 || ov_cnt != 0) begin
      failures++;
      $display("FAIL random_flags: got fe=%0d ov=%0d expected fe=0 ov=0", fe_cnt, ov_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_overrun();
    test_framing();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
